alu_issue_stage: RTL and testbench

ID/EX issue stage for the pipelined MIPS datapath: decodes the opcode/funct of one instruction into the 4-bit ALU control code, selects and registers the two signed 16-bit operands, and presents them to the ALU with a valid/ready handshake. Multiply and divide ops are held for a parameterised number of cycles before being marked valid, so the combinational ALU settles before EX/MEM captures the result.

---
 rtl/alu_issue_stage.sv | 232 +++++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//
// ID/EX issue stage of the pipelined MIPS datapath. It decodes opcode/funct
// into a 4-bit ALU control code and selects the two signed 16-bit operands.
// It registers them and presents them to the combinational ALU with a
// valid/ready handshake. Multiply and divide are held in the stage for
// MUL_CYCLES / DIV_CYCLES cycles before out_valid rises. This gives the ALU
// time to settle before EX/MEM captures the result.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   upstream handshake (in_ready depends on state and
//                       out_ready only)
//   opcode, funct       instruction[31:26], instruction[5:0]
//   rs_val, rt_val, imm register values and sign-extended immediate
//   flush               synchronous squash; overrides everything else
//   alu_op1, alu_op2    registered operands to the ALU
//   alu_ctrl            registered ALU control code
//   out_valid/out_ready downstream handshake
//   illegal_op          held op was undecodable
//   div_zero            held op was a divide by zero
// ---------------------------------------------------------------------------
module alu_issue_stage #(
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [15:0] rs_val,
  input  logic [15:0] rt_val,
  input  logic [15:0] imm,
  input  logic        flush,
  output logic [15:0] alu_op1,
  output logic [15:0] alu_op2,
  output logic [3:0]  alu_ctrl,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        illegal_op,
  output logic        div_zero
);

  // ALU control codes
  localparam logic [3:0] CTRL_ADD   = 4'b0000;
  localparam logic [3:0] CTRL_SUB   = 4'b0001;
  localparam logic [3:0] CTRL_DIV   = 4'b0010;
  localparam logic [3:0] CTRL_MUL   = 4'b0011;
  localparam logic [3:0] CTRL_PASS2 = 4'b0100;
  localparam logic [3:0] CTRL_AND   = 4'b0110;
  localparam logic [3:0] CTRL_OR    = 4'b0111;
  localparam logic [3:0] CTRL_ADDR  = 4'b1000;
  localparam logic [3:0] CTRL_NOP   = 4'b1001;

  // Opcodes and R-type functs
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] FN_ADD    = 6'b100000;
  localparam logic [5:0] FN_SUB    = 6'b100010;
  localparam logic [5:0] FN_DIV    = 6'b011010;
  localparam logic [5:0] FN_MUL    = 6'b011000;
  localparam logic [5:0] FN_AND    = 6'b100100;
  localparam logic [5:0] FN_OR     = 6'b100101;

  localparam int MAX_LAT = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_BUSY,
    S_VALID
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;

  // Decoded view of the instruction currently on the inputs
  logic [3:0]        raw_ctrl;
  logic [15:0]       raw_op2;
  logic              raw_legal;
  logic [3:0]        dec_ctrl;
  logic [15:0]       dec_op1;
  logic [15:0]       dec_op2;
  logic              dec_ill;
  logic              dec_dz;
  logic              dec_multi;
  logic [CNT_W-1:0]  dec_cnt;
  logic              accept;

  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    raw_ctrl  = CTRL_NOP;
    raw_op2   = '0;
    raw_legal = 1'b1;
    case (opcode)
      OPC_RTYPE: begin
        raw_op2 = rt_val;
        case (funct)
          FN_ADD:  raw_ctrl = CTRL_ADD;
          FN_SUB:  raw_ctrl = CTRL_SUB;
          FN_DIV:  raw_ctrl = CTRL_DIV;
          FN_MUL:  raw_ctrl = CTRL_MUL;
          FN_AND:  raw_ctrl = CTRL_AND;
          FN_OR:   raw_ctrl = CTRL_OR;
          default: raw_legal = 1'b0;
        endcase
      end
      OPC_ADDI: begin
        raw_ctrl = CTRL_ADD;
        raw_op2  = imm;
      end
      OPC_LW, OPC_SW: begin
        raw_ctrl = CTRL_ADDR;
        raw_op2  = imm;
      end
      OPC_LUI: begin
        raw_ctrl = CTRL_PASS2;
        raw_op2  = imm;
      end
      OPC_BEQ: begin
        raw_ctrl = CTRL_SUB;
        raw_op2  = rt_val;
      end
      default: raw_legal = 1'b0;
    endcase
  end

  // Illegal ops and divide-by-zero both become zero-operand no-ops.
  // A divide by zero also loses its multi-cycle hold.
  always_comb begin
    dec_ctrl = raw_ctrl;
    dec_op1  = rs_val;
    dec_op2  = raw_op2;
    dec_ill  = 1'b0;
    dec_dz   = 1'b0;
    if (!raw_legal) begin
      dec_ctrl = CTRL_NOP;
      dec_op1  = '0;
      dec_op2  = '0;
      dec_ill  = 1'b1;
    end else if (raw_ctrl == CTRL_DIV && rt_val == 16'h0000) begin
      dec_ctrl = CTRL_NOP;
      dec_op1  = '0;
      dec_op2  = '0;
      dec_dz   = 1'b1;
    end
  end

  // The BUSY counter is loaded with LAT-1. It leaves BUSY on the cycle the
  // counter reaches zero, so out_valid rises LAT-1 edges after accept.
  always_comb begin
    dec_multi = 1'b0;
    dec_cnt   = '0;
    if (dec_ctrl == CTRL_MUL && MUL_CYCLES > 1) begin
      dec_multi = 1'b1;
      dec_cnt   = CNT_W'(MUL_CYCLES - 1);
    end else if (dec_ctrl == CTRL_DIV && DIV_CYCLES > 1) begin
      dec_multi = 1'b1;
      dec_cnt   = CNT_W'(DIV_CYCLES - 1);
    end
  end

  assign in_ready = (state == S_EMPTY) || (state == S_VALID && out_ready);
  assign accept   = in_valid && in_ready;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_EMPTY;
      cnt        <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_ctrl   <= CTRL_NOP;
      out_valid  <= 1'b0;
      illegal_op <= 1'b0;
      div_zero   <= 1'b0;
    end else if (flush) begin
      state      <= S_EMPTY;
      cnt        <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_ctrl   <= CTRL_NOP;
      out_valid  <= 1'b0;
      illegal_op <= 1'b0;
      div_zero   <= 1'b0;
    end else if (accept) begin
      // Load from EMPTY, or replace a VALID op that is leaving this cycle
      alu_op1    <= dec_op1;
      alu_op2    <= dec_op2;
      alu_ctrl   <= dec_ctrl;
      illegal_op <= dec_ill;
      div_zero   <= dec_dz;
      cnt        <= dec_cnt;
      state      <= dec_multi ? S_BUSY : S_VALID;
      out_valid  <= !dec_multi;
    end else begin
      case (state)
        S_BUSY: begin
          // out_ready is deliberately ignored while the ALU settles
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state     <= S_VALID;
            out_valid <= 1'b1;
          end
        end
        S_VALID: begin
          if (out_ready) begin
            state      <= S_EMPTY;
            cnt        <= '0;
            alu_op1    <= '0;
            alu_op2    <= '0;
            alu_ctrl   <= CTRL_NOP;
            out_valid  <= 1'b0;
            illegal_op <= 1'b0;
            div_zero   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_stage
//
// Self-checking bench for alu_issue_stage. Each accepted instruction's
// expected ALU presentation comes from a small reference decoder. It is
// queued when the handshake completes and compared when EX/MEM takes it.
// Directed checks cover latency, backpressure, flush and async reset.
// ---------------------------------------------------------------------------
module tb_alu_issue_stage;

  localparam int MUL_CYCLES = 2;
  localparam int DIV_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] rs_val;
  logic [15:0] rt_val;
  logic [15:0] imm;
  logic        flush;
  logic [15:0] alu_op1;
  logic [15:0] alu_op2;
  logic [3:0]  alu_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic        illegal_op;
  logic        div_zero;

  alu_issue_stage #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .funct      (funct),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .imm        (imm),
    .flush      (flush),
    .alu_op1    (alu_op1),
    .alu_op2    (alu_op2),
    .alu_ctrl   (alu_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .illegal_op (illegal_op),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [15:0] op1;
    logic [15:0] op2;
    logic        ill;
    logic        dz;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference decoder written from the instruction table
  function automatic exp_t model(input logic [5:0] opc, input logic [5:0] fn,
                                 input logic [15:0] rs, input logic [15:0] rt,
                                 input logic [15:0] im);
    exp_t e;
    e = '{ctrl: 4'b1001, op1: 16'h0, op2: 16'h0, ill: 1'b0, dz: 1'b0};
    if (opc == 6'h00 && fn == 6'h20)      e = '{4'b0000, rs, rt, 1'b0, 1'b0};
    else if (opc == 6'h00 && fn == 6'h22) e = '{4'b0001, rs, rt, 1'b0, 1'b0};
    else if (opc == 6'h00 && fn == 6'h18) e = '{4'b0011, rs, rt, 1'b0, 1'b0};
    else if (opc == 6'h00 && fn == 6'h24) e = '{4'b0110, rs, rt, 1'b0, 1'b0};
    else if (opc == 6'h00 && fn == 6'h25) e = '{4'b0111, rs, rt, 1'b0, 1'b0};
    else if (opc == 6'h00 && fn == 6'h1a) begin
      if (rt == 16'h0) e.dz = 1'b1;
      else             e = '{4'b0010, rs, rt, 1'b0, 1'b0};
    end
    else if (opc == 6'h08)                e = '{4'b0000, rs, im, 1'b0, 1'b0};
    else if (opc == 6'h23 || opc == 6'h2b) e = '{4'b1000, rs, im, 1'b0, 1'b0};
    else if (opc == 6'h0f)                e = '{4'b0100, rs, im, 1'b0, 1'b0};
    else if (opc == 6'h04)                e = '{4'b0001, rs, rt, 1'b0, 1'b0};
    else                                  e.ill = 1'b1;
    return e;
  endfunction

  // Scoreboard: EX/MEM takes the op at the coming rising edge
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready && !flush) begin
      check("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) begin
        mon_e = sb_q.pop_front();
        check("sb_ctrl", 32'(alu_ctrl), 32'(mon_e.ctrl));
        check("sb_op1", 32'(alu_op1), 32'(mon_e.op1));
        check("sb_op2", 32'(alu_op2), 32'(mon_e.op2));
        check("sb_illegal", 32'(illegal_op), 32'(mon_e.ill));
        check("sb_divzero", 32'(div_zero), 32'(mon_e.dz));
      end
    end
  end

  // Present one instruction and hold it until accepted. Returns at 1 ns after
  // the accepting edge, with in_valid dropped. 'waits' counts refused cycles.
  task automatic send(input logic [5:0] opc, input logic [5:0] fn,
                      input logic [15:0] rs, input logic [15:0] rt,
                      input logic [15:0] im, output int waits);
    bit done;
    done  = 1'b0;
    waits = 0;
    opcode   = opc;
    funct    = fn;
    rs_val   = rs;
    rt_val   = rt;
    imm      = im;
    in_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        sb_q.push_back(model(opc, fn, rs, rt, im));
        done = 1'b1;
      end else begin
        waits++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("send_accepted", 32'(done), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  w;
    int  lat;
    bit  saw_valid;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    opcode    = '0;
    funct     = '0;
    rs_val    = '0;
    rt_val    = '0;
    imm       = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    // Reset values
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_ctrl", 32'(alu_ctrl), 32'h9);
    check("rst_op1", 32'(alu_op1), 32'h0);
    check("rst_op2", 32'(alu_op2), 32'h0);
    check("rst_illegal", 32'(illegal_op), 32'd0);
    check("rst_divzero", 32'(div_zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Single-cycle add, then a back-to-back stream
    out_ready = 1'b1;
    send(6'h00, 6'h20, 16'd5, 16'hFFFD, 16'h0, w);
    check("add_valid", 32'(out_valid), 32'd1);
    check("add_ctrl", 32'(alu_ctrl), 32'h0);
    send(6'h00, 6'h22, 16'd10, 16'd3, 16'h0, w);    check("stream_wait", 32'(w), 32'd0);
    send(6'h0f, 6'h00, 16'd1, 16'd2, 16'h1234, w);  check("stream_wait", 32'(w), 32'd0);
    send(6'h2b, 6'h00, 16'd40, 16'd9, 16'h0010, w); check("stream_wait", 32'(w), 32'd0);
    send(6'h04, 6'h00, 16'd7, 16'd7, 16'h0, w);     check("stream_wait", 32'(w), 32'd0);
    send(6'h00, 6'h24, 16'hF0F0, 16'h0FF0, 16'h0, w); check("stream_wait", 32'(w), 32'd0);
    send(6'h00, 6'h25, 16'hF000, 16'h000F, 16'h0, w); check("stream_wait", 32'(w), 32'd0);
    send(6'h08, 6'h00, 16'd100, 16'd0, 16'hFFFF, w);  check("stream_wait", 32'(w), 32'd0);
    check("stream_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    check("stream_drained", 32'(out_valid), 32'd0);

    // Multiply: one BUSY cycle, operands already presented
    send(6'h00, 6'h18, 16'd7, 16'd6, 16'h0, w);
    check("mul_busy_valid", 32'(out_valid), 32'd0);
    check("mul_busy_ready", 32'(in_ready), 32'd0);
    check("mul_busy_ctrl", 32'(alu_ctrl), 32'h3);
    @(posedge clk); #1;
    check("mul_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #1;

    // Divide: out_valid three edges after accept, in_ready low meanwhile
    send(6'h00, 6'h1a, 16'd20, 16'd4, 16'h0, w);
    check("div_busy_ready", 32'(in_ready), 32'd0);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (out_valid) lat = i;
      else check("div_busy_ready", 32'(in_ready), 32'd0);
    end
    check("div_latency", 32'(lat), 32'd3);
    @(posedge clk); #1;

    // Divide by zero (single-cycle), then an illegal opcode
    send(6'h00, 6'h1a, 16'd20, 16'd0, 16'h0, w);
    check("dz_valid", 32'(out_valid), 32'd1);
    check("dz_flag", 32'(div_zero), 32'd1);
    send(6'h3f, 6'h00, 16'd1, 16'd2, 16'h3, w);
    check("ill_flag", 32'(illegal_op), 32'd1);
    check("ill_ctrl", 32'(alu_ctrl), 32'h9);
    @(posedge clk); #1;

    // lw under backpressure; a competing sw must not disturb it
    out_ready = 1'b0;
    send(6'h23, 6'h00, 16'd100, 16'd0, 16'hFFF8, w);
    opcode   = 6'h2b;
    imm      = 16'h0042;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_ctrl", 32'(alu_ctrl), 32'h8);
      check("bp_op2", 32'(alu_op2), 32'hFFF8);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_released", 32'(out_valid), 32'd0);

    // Flush during the BUSY of a divide
    send(6'h00, 6'h1a, 16'd20, 16'd4, 16'h0, w);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    sb_q.delete();
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_ctrl", 32'(alu_ctrl), 32'h9);
    check("flush_op1", 32'(alu_op1), 32'h0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    saw_valid = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      saw_valid |= out_valid;
    end
    check("flush_no_valid", 32'(saw_valid), 32'd0);

    // Flush together with in_valid drops the op
    opcode   = 6'h00;
    funct    = 6'h20;
    rs_val   = 16'd3;
    rt_val   = 16'd4;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_in_valid", 32'(out_valid), 32'd0);
    check("flush_in_ctrl", 32'(alu_ctrl), 32'h9);

    // Asynchronous reset in the middle of a multiply
    send(6'h00, 6'h18, 16'd7, 16'd6, 16'h0, w);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_ctrl", 32'(alu_ctrl), 32'h9);
    check("arst_op1", 32'(alu_op1), 32'h0);
    check("arst_op2", 32'(alu_op2), 32'h0);
    check("arst_valid", 32'(out_valid), 32'd0);
    sb_q.delete();
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_op_lost", 32'(out_valid), 32'd0);
    send(6'h00, 6'h20, 16'd1, 16'd2, 16'h0, w);
    check("arst_next_valid", 32'(out_valid), 32'd1);
    check("arst_next_ctrl", 32'(alu_ctrl), 32'h0);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
